// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared AES-128 types and constants: S-box, round constants, word/block types
// and the key-schedule FSM encoding. Byte 0 of a word/block is the leftmost (bits 0:7).
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef logic [0:31]  aes_word_t;
  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } key_sched_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by the round number being generated.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load handshake, round-key read port and status of the AES-128 key-schedule controller.
interface aes_key_schedule_ctrl_if
  import aes_pkg::*;
#(
  parameter int RK_AW = 4
);
  // Key load: a transfer happens on a rising edge where key_valid_in && key_ready;
  // key_in must be stable while key_valid_in is high. key_valid_in with key_ready low
  // is dropped, not held pending. Read port: rk_rd_en at edge n yields rk_rd_data and
  // a one-cycle rk_rd_valid after edge n; there is no backpressure.
  aes_block_t       key_in;
  logic             key_valid_in;
  logic             key_ready;
  logic             busy;
  logic             sched_valid;
  logic             rk_rd_en;
  logic [RK_AW-1:0] rk_rd_addr;
  aes_block_t       rk_rd_data;
  logic             rk_rd_valid;
  logic             zeroize;
  key_sched_state_e dbg_state;

  modport master (
    output key_in, key_valid_in, rk_rd_en, rk_rd_addr, zeroize,
    input  key_ready, busy, sched_valid, rk_rd_data, rk_rd_valid, dbg_state
  );

  modport slave (
    input  key_in, key_valid_in, rk_rd_en, rk_rd_addr, zeroize,
    output key_ready, busy, sched_valid, rk_rd_data, rk_rd_valid, dbg_state
  );

endinterface

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word. Shared with the round engine.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word,
  output aes_word_t subbed
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign subbed[8*i +: 8] = SBOX[word[8*i +: 8]];
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry store with a
// registered read port. Optional zeroize is enabled by defining AES_KEY_SCHED_ZEROIZE_EN.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_AW      = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  aes_key_schedule_ctrl_if.slave kif
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
    $error("aes_key_schedule_ctrl supports only NUM_ROUNDS = 10");
  end

  key_sched_state_e state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  aes_block_t       prev_q, prev_d;
  aes_block_t       rk [0:NUM_ROUNDS];
  aes_block_t       rd_data_q;
  logic             rd_valid_q;

  logic       ready, accept, zero_req, wr_en;
  logic [3:0] wr_addr;
  aes_block_t wr_data, next_key;
  aes_word_t  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign zero_req = kif.zeroize;
`else
  logic unused_zeroize;
  assign unused_zeroize = kif.zeroize;
  assign zero_req       = 1'b0;
`endif

  // prev_q always mirrors rk[rnd_q-1], so the expansion never needs a read mux on the store.
  assign w0  = prev_q[0:31];
  assign w1  = prev_q[32:63];
  assign w2  = prev_q[64:95];
  assign w3  = prev_q[96:127];
  assign rot = {w3[8:31], w3[0:7]};

  aes_sub_word u_sub_word (
    .word   (rot),
    .subbed (sub)
  );

  assign t        = sub ^ {RCON[rnd_q], 24'h000000};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign ready  = (state_q != EXPAND);
  assign accept = kif.key_valid_in && ready;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    prev_d  = prev_q;
    wr_en   = 1'b0;
    wr_addr = rnd_q;
    wr_data = next_key;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = EXPAND;
          rnd_d   = 4'd1;
          prev_d  = kif.key_in;
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_data = kif.key_in;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        prev_d = next_key;
        rnd_d  = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_ROUNDS)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Zeroize wins over everything, including a key accepted in the same cycle.
    if (zero_req) begin
      state_d = IDLE;
      rnd_d   = 4'd0;
      prev_d  = '0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      prev_q  <= prev_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        if (zero_req) rk[i] <= '0;
        else if (wr_en && (wr_addr == 4'(i))) rk[i] <= wr_data;
      end
    end
  end

  // Reads sample the store before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= kif.rk_rd_en;
      if (zero_req) rd_data_q <= '0;
      else if (kif.rk_rd_en)
        rd_data_q <= (kif.rk_rd_addr > RK_AW'(NUM_ROUNDS)) ? '0 : rk[kif.rk_rd_addr];
    end
  end

  assign kif.key_ready   = ready;
  assign kif.busy        = (state_q == EXPAND);
  assign kif.sched_valid = (state_q == DONE);
  assign kif.rk_rd_data  = rd_data_q;
  assign kif.rk_rd_valid = rd_valid_q;
  assign kif.dbg_state   = state_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl: FIPS-197 vectors, randomized keys, read port,
// reset/abort behaviour and zeroize (expectations follow AES_KEY_SCHED_ZEROIZE_EN).
module tb_aes_key_schedule_ctrl;
  import aes_pkg::*;

  localparam int RK_AW = 4;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_schedule_ctrl_if #(.RK_AW(RK_AW)) kif ();

  aes_key_schedule_ctrl #(.NUM_ROUNDS(10), .RK_AW(RK_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model_rk[11];
  logic [7:0]   sbox_m[256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine transform.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  // FIPS-197 word-oriented KeyExpansion over w[0..43].
  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 11; r++) model_rk[r] = '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_one(input logic [RK_AW-1:0] a, input logic [127:0] e, input string tag);
    kif.rk_rd_en   = 1'b1;
    kif.rk_rd_addr = a;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check({tag, "_vld"}, 128'(kif.rk_rd_valid), 128'd1);
    check(tag, kif.rk_rd_data, exp_q.pop_front());
  endtask

  task automatic read_burst(input int n, input bit rand_addr, input string tag);
    logic [RK_AW-1:0] a;
    logic [127:0]     e;
    logic [127:0]     last;
    last = '0;
    for (int i = 0; i < n; i++) begin
      a    = rand_addr ? RK_AW'($urandom_range(0, 15)) : RK_AW'(i);
      e    = (a <= 10) ? model_rk[a] : '0;
      last = e;
      read_one(a, e, tag);
    end
    kif.rk_rd_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_vld"}, 128'(kif.rk_rd_valid), 128'd0);
    check({tag, "_hold"}, kif.rk_rd_data, last);
  endtask

  task automatic expand_key(input logic [127:0] k, input bit pulse, input bit collide,
                            input string tag);
    int cyc;
    kif.key_in       = k;
    kif.key_valid_in = 1'b1;
    if (collide) begin
      kif.rk_rd_en   = 1'b1;
      kif.rk_rd_addr = '0;
      exp_q.push_back(model_rk[0]);
    end
    @(posedge clk); #1;
    cyc              = 1;
    kif.key_valid_in = 1'b0;
    kif.key_in       = {$urandom, $urandom, $urandom, $urandom};
    check({tag, "_acc_busy"}, 128'(kif.busy), 128'd1);
    check({tag, "_acc_rdy"}, 128'(kif.key_ready), 128'd0);
    check({tag, "_acc_sv"}, 128'(kif.sched_valid), 128'd0);
    if (collide) begin
      check({tag, "_col0"}, kif.rk_rd_data, exp_q.pop_front());
      kif.rk_rd_addr = RK_AW'(1);
      exp_q.push_back(model_rk[1]);
    end
    while (!kif.sched_valid && cyc < 40) begin
      if (pulse && (cyc == 3 || cyc == 7)) begin
        kif.key_valid_in = 1'b1;
        check({tag, "_ign_rdy"}, 128'(kif.key_ready), 128'd0);
      end
      @(posedge clk); #1;
      cyc++;
      kif.key_valid_in = 1'b0;
      if (collide && cyc == 2) begin
        check({tag, "_col1"}, kif.rk_rd_data, exp_q.pop_front());
        kif.rk_rd_en = 1'b0;
      end
    end
    check({tag, "_lat"}, 128'(cyc), 128'd11);
    check({tag, "_done_busy"}, 128'(kif.busy), 128'd0);
    check({tag, "_done_rdy"}, 128'(kif.key_ready), 128'd1);
    model_expand(k);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 128'(kif.key_ready), 128'd1);
    check({tag, "_busy"}, 128'(kif.busy), 128'd0);
    check({tag, "_sv"}, 128'(kif.sched_valid), 128'd0);
    check({tag, "_vld"}, 128'(kif.rk_rd_valid), 128'd0);
    check({tag, "_data"}, kif.rk_rd_data, 128'd0);
    check({tag, "_state"}, 128'(kif.dbg_state), 128'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k;
    int           cyc;
    build_sbox();
    kif.key_in       = '0;
    kif.key_valid_in = 1'b0;
    kif.rk_rd_en     = 1'b0;
    kif.rk_rd_addr   = '0;
    kif.zeroize      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    model_clear();
    read_burst(12, 1'b0, "rst_rd");

    // Known-answer vectors; the zero key also reads entries 0/1 while they are rewritten.
    expand_key(FIPS_KEY, 1'b0, 1'b0, "fips");
    read_one(RK_AW'(1), FIPS_RK1, "fips_rk1");
    read_one(RK_AW'(10), FIPS_RK10, "fips_rk10");
    read_burst(12, 1'b0, "fips_rd");
    expand_key('0, 1'b0, 1'b1, "zero");
    read_one(RK_AW'(1), ZERO_RK1, "zero_rk1");
    read_one(RK_AW'(10), ZERO_RK10, "zero_rk10");
    read_burst(12, 1'b0, "zero_rd");

    // Key offers during EXPAND at cycles 3 and 7 must be dropped.
    k = {$urandom, $urandom, $urandom, $urandom};
    expand_key(k, 1'b1, 1'b0, "ign");
    read_burst(12, 1'b0, "ign_rd");

    // Asynchronous reset at cycle 5 of an expansion.
    k                = {$urandom, $urandom, $urandom, $urandom};
    kif.key_in       = k;
    kif.key_valid_in = 1'b1;
    @(posedge clk); #1;
    kif.key_valid_in = 1'b0;
    cyc              = 1;
    while (cyc < 5) begin
      if (cyc == 4) begin
        kif.rk_rd_en   = 1'b1;
        kif.rk_rd_addr = '0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    kif.rk_rd_en = 1'b0;
    check("mid_rd", kif.rk_rd_data, k);
    check("mid_busy", 128'(kif.busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mrst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    read_burst(12, 1'b0, "mrst_rd");
    expand_key(FIPS_KEY, 1'b0, 1'b0, "refips");
    read_one(RK_AW'(10), FIPS_RK10, "refips_rk10");
    kif.rk_rd_en = 1'b0;

    // Randomized keys with random read addresses (including out-of-range ones).
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand_key(k, 1'b0, (n % 2) == 1, "rnd");
      read_burst(10, 1'b1, "rnd_rd");
    end

    // Zeroize pulse in DONE.
    read_one(RK_AW'(10), model_rk[10], "pre_zero");
    kif.rk_rd_en = 1'b0;
    kif.zeroize  = 1'b1;
    @(posedge clk); #1;
    kif.zeroize = 1'b0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    check("zero_sv", 128'(kif.sched_valid), 128'd0);
    check("zero_state", 128'(kif.dbg_state), 128'(IDLE));
    check("zero_data", kif.rk_rd_data, 128'd0);
    model_clear();
`else
    check("zero_sv", 128'(kif.sched_valid), 128'd1);
    check("zero_state", 128'(kif.dbg_state), 128'(DONE));
    check("zero_data", kif.rk_rd_data, model_rk[10]);
`endif
    read_burst(11, 1'b0, "zero_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
